// File: rtl/scaled_mul_if.sv
// scaled_mul_if -- handshake bundle for the scaled-format multiplier.
//
// Signals:
//   in_valid / in_ready   : operand handshake (a, b accepted when both high)
//   a, b                  : operands, [15:13] unsigned scale, [12:0] signed mantissa
//   out_valid / out_ready : result handshake (result held until out_ready)
//   out                   : product in the same scaled format
//   invalid               : product mantissa did not fit in 13 signed bits
//
// Modports: master drives operands and out_ready; slave is the multiplier.
interface scaled_mul_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        invalid;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, invalid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, invalid
  );
endinterface

// File: rtl/scaled_mul_seq.sv
// scaled_mul_seq -- sequential multiplier for the scaled fixed-point format
// (value = mantissa / 2^scale). Sign-magnitude radix-2 shift-add over 13
// cycles, then one cycle that reapplies the sign, rescales the product to the
// larger operand scale and flags mantissa overflow.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : scaled_mul_if.slave (operand and result handshakes)
//
// Timing: operands accepted at edge k give out_valid after edge k+14; the
// result is held until out_ready. Operands are only taken in IDLE.
module scaled_mul_seq (
  input  logic         clk,
  input  logic         rst_n,
  scaled_mul_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [25:0] acc_q, acc_d;
  logic [12:0] mag_a_q, mag_a_d;
  logic [12:0] mag_b_q, mag_b_d;
  logic [2:0]  scale_a_q, scale_a_d;
  logic [2:0]  scale_b_q, scale_b_d;
  logic        neg_q, neg_d;
  logic [15:0] out_q, out_d;
  logic        invalid_q, invalid_d;

  // Datapath helpers, only consumed in MUL / SHIFT.
  logic [25:0]        addend;
  logic signed [25:0] prod;
  logic signed [25:0] res;
  logic [2:0]         scale_min;
  logic [2:0]         scale_max;
  logic [12:0]        abs_a;
  logic [12:0]        abs_b;

  // Two's-complement magnitude; -4096 maps to 13'h1000, which is exactly 4096
  // when read as unsigned, so no extra bit is needed.
  always_comb begin
    abs_a = bus.a[12] ? (~bus.a[12:0] + 13'd1) : bus.a[12:0];
    abs_b = bus.b[12] ? (~bus.b[12:0] + 13'd1) : bus.b[12:0];
  end

  always_comb begin
    addend = '0;
    if (mag_b_q[cnt_q]) addend = {13'd0, mag_a_q} << cnt_q;

    scale_min = (scale_a_q < scale_b_q) ? scale_a_q : scale_b_q;
    scale_max = (scale_a_q < scale_b_q) ? scale_b_q : scale_a_q;

    prod = neg_q ? -acc_q : acc_q;
    // Arithmetic shift on a signed operand floors, i.e. truncates toward -inf.
    res  = prod >>> scale_min;
  end

  // NOTE: every variable gets its default first so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    scale_a_d = scale_a_q;
    scale_b_d = scale_b_q;
    neg_d     = neg_q;
    out_d     = out_q;
    invalid_d = invalid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mag_a_d   = abs_a;
          mag_b_d   = abs_b;
          scale_a_d = bus.a[15:13];
          scale_b_d = bus.b[15:13];
          neg_d     = bus.a[12] ^ bus.b[12];
          cnt_d     = '0;
          acc_d     = '0;
          state_d   = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd12) state_d = SHIFT;
      end
      SHIFT: begin
        out_d     = {scale_max, res[12:0]};
        invalid_d = ~((res[25:12] == '0) || (res[25:12] == '1));
        state_d   = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order. Operand registers are
  // reset too, keeping the datapath X-free after reset at negligible cost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      scale_a_q <= '0;
      scale_b_q <= '0;
      neg_q     <= 1'b0;
      out_q     <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      scale_a_q <= scale_a_d;
      scale_b_q <= scale_b_d;
      neg_q     <= neg_d;
      out_q     <= out_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.invalid   = invalid_q;

endmodule

// File: doc/scaled_mul_seq.md
SCALED_MUL_SEQ -- requirements
Module: scaled_mul_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports are listed below, clock and reset first.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  operands a, b are presented.
REQ-005 in_ready  out  1  block can accept operands.
REQ-006 a  in  16  operand 1 in scaled format: [15:13] unsigned scale s, [12:0] signed mantissa m; value = m / 2^s.
REQ-007 b  in  16  operand 2, same format as a.
REQ-008 out_valid  out  1  result is held and valid.
REQ-009 out_ready  in  1  downstream (add/sub stage) consumes the result.
REQ-010 out  out  16  product in scaled format, same as a.
REQ-011 invalid  out  1  the result mantissa did not fit in 13 signed bits.

Function
REQ-012 FSM states SHALL be IDLE, MUL, SHIFT and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 IDLE: on an edge with in_valid=1, the block SHALL latch a and b, go to MUL and clear the iteration counter; otherwise it stays in IDLE.
REQ-014 Latch step: the block SHALL store the sign of each mantissa (sa = a[12], sb = b[12]) and the 13-bit magnitudes; |-4096| = 4096 exactly.
REQ-015 MUL: the block SHALL run a radix-2 shift-add on the magnitudes, one multiplier bit per edge, into a 26-bit accumulator.
REQ-016 MUL SHALL last exactly 13 edges, counter 0..12; the edge on which the counter is 12 goes to SHIFT.
REQ-017 SHIFT (one edge): the block SHALL form the signed product P = (sa^sb) ? -acc : acc, 26-bit two's complement.
REQ-018 SHIFT: target scale T = max(sa_scale, sb_scale).
REQ-019 SHIFT: R = P arithmetic-shifted right by min(sa_scale, sb_scale); this truncates toward minus infinity.
REQ-020 SHIFT: out[15:13] = T and out[12:0] = R[12:0].
REQ-021 SHIFT: invalid = 1 unless R[25:12] is all zeros or all ones; then go to DONE.
REQ-022 DONE: on an edge with out_ready=1, the block SHALL go to IDLE; otherwise it holds out_valid, out and invalid stable.
REQ-023 No operands SHALL be accepted in DONE, even if out_ready=1 on the same edge; in_valid is ignored outside IDLE.
REQ-024 Latency: with an accepting edge at k, out_valid SHALL be 1 after edge k+14. Minimum initiation interval is 16 edges with out_ready held at 1.
REQ-025 out and invalid SHALL keep their last values in every state except SHIFT, which updates them.
REQ-026 A zero product SHALL give mantissa 0 with invalid=0, at any scale.
REQ-027 Changes to a or b after the accepting edge SHALL have no effect on the result.

Reset
REQ-028 rst_n=0 SHALL immediately force:
- state IDLE, counter 0, accumulator 0;
- out=16'h0000, invalid=0, out_valid=0;
- in_ready=1 once the FSM is in IDLE.
REQ-029 A reset asserted mid-operation (MUL, SHIFT or DONE) SHALL discard the operation; no result is produced after release.
REQ-030 After rst_n deasserts, the first accepting edge SHALL behave exactly as after power-up.

Verification
REQ-031 Equal scales: a=16'h8030 (3.0), b=16'h8028 (2.5) -> after 14 edges out=16'h8078 (7.5), invalid=0.
REQ-032 Mixed scales and sign: a=16'h5FF4 (-3.0, s=2), b=16'hA040 (2.0, s=5) -> out=16'hBF40 (-6.0, s=5), invalid=0.
REQ-033 Overflow: a=16'h0FA0 (4000, s=0), b=16'h0004 (4, s=0) -> out=16'h1E80, invalid=1.
REQ-034 Truncation toward minus infinity: a=16'h3FFF (-0.5, s=1), b=16'h2001 (0.5, s=1) -> out=16'h3FFF (-0.5), invalid=0. Also: 0 x anything -> mantissa 0, invalid=0.
REQ-035 Backpressure:
- hold out_ready=0 for 20 edges -> out_valid, out and invalid stay stable, in_ready=0;
- pulse out_ready -> IDLE on the next edge;
- a second operand pair presented while in DONE is not taken.
REQ-036 Reset mid-MUL: assert rst_n=0 at edge k+5 -> outputs return to reset values at once; no out_valid appears; the next operation gives the correct result.
